// File: rtl/serial_exec_ctrl.sv
// serial_exec_ctrl
//   Sequencer for a bit-serial execution unit. An accepted instruction walks
//   through its phases. READ_A, then READ_B or LOAD_IMM, then EXEC and WRITE
//   each last WIDTH cycles. A one-cycle DONE follows. All datapath enables
//   are decoded from the current state and the bit counter.
//
//   Optional feature: define SERIAL_REG_WB_EN to drive reg_write_en during
//   WRITE. When it is not defined, reg_write_en is tied to 0.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   start                  execute request, sampled only in IDLE
//   opcode[3:0]            bit3=1 immediate form, bit3=0 register form
//   rs1, rs2, rd [AW-1:0]  source / destination register addresses
//   busy                   high in every state except IDLE
//   done, illegal          completion pulse; illegal qualifies done
//   reg_addr [AW-1:0]      register-file address for the current phase
//   reg_read_en            register-file shift-out enable
//   reg_write_en           register-file shift-in enable
//   imm_shift_en           immediate shift enable
//   acc_shift_en           accumulator shift enable
//   alu_op[1:0]            00 ADD/SUB, 01 XOR, 10 AND, 11 OR
//   sub_en                 invert operand B
//   carry_init             load the carry flop
//   carry_en               update the carry flop
//   bit_idx [CW-1:0]       bit position in the active phase
//   dbg_state[2:0]         current FSM state, for observation
module serial_exec_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 3,
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [3:0]    opcode,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    output logic          busy,
    output logic          done,
    output logic          illegal,
    output logic [AW-1:0] reg_addr,
    output logic          reg_read_en,
    output logic          reg_write_en,
    output logic          imm_shift_en,
    output logic          acc_shift_en,
    output logic [1:0]    alu_op,
    output logic          sub_en,
    output logic          carry_init,
    output logic          carry_en,
    output logic [CW-1:0] bit_idx,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ_A, S_READ_B, S_LOAD_IMM, S_EXEC, S_WRITE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q;
    logic [AW-1:0] rs1_q, rs2_q, rd_q;
    logic          accept;
    logic          last_bit;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110,
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_decode(input logic [3:0] op);
        case (op)
            4'b0110, 4'b1100: alu_decode = 2'b01;   // XOR / XORI
            4'b0101, 4'b1011: alu_decode = 2'b10;   // AND / ANDI
            4'b0100, 4'b1010: alu_decode = 2'b11;   // OR  / ORI
            default:          alu_decode = 2'b00;   // ADD / SUB / ADDI / SUBI
        endcase
    endfunction

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q  <= opcode;
                rs1_q <= rs1;
                rs2_q <= rs2;
                rd_q  <= rd;
            end
        end
    end

    // Next state. The counter wraps to 0 on the same edge that leaves a
    // phase, so every serial phase starts at bit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = is_legal(opcode) ? S_READ_A : S_DONE;
                end
            end
            S_READ_A, S_READ_B, S_LOAD_IMM, S_EXEC, S_WRITE: begin
                cnt_d = last_bit ? '0 : cnt_q + 1'b1;
                if (last_bit) begin
                    case (state_q)
                        S_READ_A:            state_d = op_q[3] ? S_LOAD_IMM : S_READ_B;
                        S_READ_B, S_LOAD_IMM: state_d = S_EXEC;
                        S_EXEC:              state_d = S_WRITE;
                        default:             state_d = S_DONE;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state. Reset therefore drives them
    // all to 0 immediately.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        reg_addr     = '0;
        reg_read_en  = 1'b0;
        reg_write_en = 1'b0;
        imm_shift_en = 1'b0;
        acc_shift_en = 1'b0;
        alu_op       = 2'b00;
        sub_en       = 1'b0;
        carry_init   = 1'b0;
        carry_en     = 1'b0;
        bit_idx      = '0;
        case (state_q)
            S_READ_A: begin
                busy        = 1'b1;
                reg_read_en = 1'b1;
                reg_addr    = rs1_q;
                bit_idx     = cnt_q;
            end
            S_READ_B: begin
                busy        = 1'b1;
                reg_read_en = 1'b1;
                reg_addr    = rs2_q;
                bit_idx     = cnt_q;
            end
            S_LOAD_IMM: begin
                busy         = 1'b1;
                imm_shift_en = 1'b1;
                bit_idx      = cnt_q;
            end
            S_EXEC: begin
                busy       = 1'b1;
                alu_op     = alu_decode(op_q);
                sub_en     = (op_q == 4'b0001) || (op_q == 4'b1001);
                carry_init = (cnt_q == '0);
                carry_en   = 1'b1;
                bit_idx    = cnt_q;
            end
            S_WRITE: begin
                busy         = 1'b1;
                acc_shift_en = 1'b1;
                reg_addr     = rd_q;
`ifdef SERIAL_REG_WB_EN
                reg_write_en = 1'b1;
`else
                reg_write_en = 1'b0;
`endif
                bit_idx      = cnt_q;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                illegal = !is_legal(op_q);
            end
            default: ;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_exec_ctrl.sv
// Directed bench for serial_exec_ctrl. It drives a WIDTH=8 instance and a
// WIDTH=16 instance. Both instances share their operand inputs, and each has
// its own start.
module tb_serial_exec_ctrl;

  typedef struct {
    logic [3:0] opcode;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic       imm;    // expected immediate form
    logic       ill;    // expected illegal
    logic [1:0] alu;    // expected alu_op in EXEC
    logic       sub;    // expected sub_en in EXEC
    logic       noise;  // hammer start / inputs while busy
  } vec_t;

  // {busy, done, illegal, reg_addr[2:0], read, write, imm, acc, alu[1:0],
  //  sub, carry_init, carry_en, bit_idx[3:0]}
  typedef logic [18:0] ob_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start8 = 1'b0, start16 = 1'b0;
  logic [3:0] opcode = '0;
  logic [2:0] rs1 = '0, rs2 = '0, rd = '0;

  logic busy8, done8, ill8, rre8, rwe8, ise8, ase8, sub8, ci8, ce8;
  logic [2:0] addr8, st8;
  logic [1:0] alu8;
  logic [2:0] idx8;
  logic busy16, done16, ill16, rre16, rwe16, ise16, ase16, sub16, ci16, ce16;
  logic [2:0] addr16, st16;
  logic [1:0] alu16;
  logic [3:0] idx16;

  int vecs = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_exec_ctrl #(.WIDTH(8), .AW(3)) dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .busy(busy8), .done(done8), .illegal(ill8), .reg_addr(addr8),
    .reg_read_en(rre8), .reg_write_en(rwe8), .imm_shift_en(ise8),
    .acc_shift_en(ase8), .alu_op(alu8), .sub_en(sub8),
    .carry_init(ci8), .carry_en(ce8), .bit_idx(idx8), .dbg_state(st8)
  );

  serial_exec_ctrl #(.WIDTH(16), .AW(3)) dut16 (
    .clk(clk), .rstn(rstn), .start(start16), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .busy(busy16), .done(done16), .illegal(ill16), .reg_addr(addr16),
    .reg_read_en(rre16), .reg_write_en(rwe16), .imm_shift_en(ise16),
    .acc_shift_en(ase16), .alu_op(alu16), .sub_en(sub16),
    .carry_init(ci16), .carry_en(ce16), .bit_idx(idx16), .dbg_state(st16)
  );

  ob_t act8, act16;
  assign act8  = {busy8, done8, ill8, addr8, rre8, rwe8, ise8, ase8, alu8,
                  sub8, ci8, ce8, 1'b0, idx8};
  assign act16 = {busy16, done16, ill16, addr16, rre16, rwe16, ise16, ase16,
                  alu16, sub16, ci16, ce16, idx16};

  // Expected outputs at cycle c after the accepting edge (c=0: before it).
  function automatic ob_t exp_out(vec_t v, int w, int c);
    int ph = 0;
    int idx = 0;
    logic busy = 0, dn = 0, il = 0, rre = 0, rwe = 0, ise = 0, ase = 0;
    logic sub = 0, ci = 0, ce = 0;
    logic [2:0] addr = '0;
    logic [1:0] alu = '0;
    if (v.ill) ph = (c == 1) ? 5 : 0;
    else if (c >= 1 && c <= 4 * w) begin
      ph = 1 + (c - 1) / w;
      idx = (c - 1) % w;
    end else if (c == 4 * w + 1) ph = 5;
    case (ph)
      1: begin busy = 1; rre = 1; addr = v.rs1; end
      2: begin
        busy = 1;
        if (v.imm) ise = 1;
        else begin rre = 1; addr = v.rs2; end
      end
      3: begin busy = 1; alu = v.alu; sub = v.sub; ce = 1; ci = (idx == 0); end
      4: begin
        busy = 1; ase = 1; addr = v.rd;
`ifdef SERIAL_REG_WB_EN
        rwe = 1;
`endif
      end
      5: begin busy = 1; dn = 1; il = v.ill; end
      default: ;
    endcase
    if (ph == 0 || ph == 5) idx = 0;
    return {busy, dn, il, addr, rre, rwe, ise, ase, alu, sub, ci, ce, 4'(idx)};
  endfunction

  task automatic check(string name, ob_t act, ob_t exp);
    vecs++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  // Issue one instruction and check every cycle through the return to IDLE.
  // stop_c > 0 returns right after the check of cycle stop_c.
  task automatic run_op(vec_t v, int w, int stop_c, string name);
    int last = v.ill ? 1 : 4 * w + 1;
    @(negedge clk);
    opcode = v.opcode; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
    if (w == 8) start8 = 1; else start16 = 1;
    check($sformatf("%s c0", name), (w == 8) ? act8 : act16, exp_out(v, w, 0));
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", name, c), (w == 8) ? act8 : act16, exp_out(v, w, c));
      if (stop_c > 0 && c == stop_c) return;
      if (v.noise && c < last) begin
        start8 = (w == 8); start16 = (w == 16);
        opcode = 4'($urandom_range(0, 15));
        rs1 = 3'($urandom_range(0, 7));
        rs2 = 3'($urandom_range(0, 7));
        rd  = 3'($urandom_range(0, 7));
      end else begin
        start8 = 0; start16 = 0;
      end
    end
  endtask

  vec_t tbl[15];
  vec_t v16;

  initial begin
    //         opcode   rs1   rs2   rd    imm ill alu    sub noise
    tbl[0]  = '{4'b0000, 3'd2, 3'd5, 3'd1, 0, 0, 2'b00, 0, 0}; // ADD
    tbl[1]  = '{4'b0001, 3'd4, 3'd3, 3'd7, 0, 0, 2'b00, 1, 0}; // SUB
    tbl[2]  = '{4'b0100, 3'd1, 3'd6, 3'd2, 0, 0, 2'b11, 0, 0}; // OR
    tbl[3]  = '{4'b0101, 3'd7, 3'd0, 3'd3, 0, 0, 2'b10, 0, 0}; // AND
    tbl[4]  = '{4'b0110, 3'd5, 3'd2, 3'd4, 0, 0, 2'b01, 0, 0}; // XOR
    tbl[5]  = '{4'b1000, 3'd6, 3'd1, 3'd5, 1, 0, 2'b00, 0, 0}; // ADDI
    tbl[6]  = '{4'b1001, 3'd3, 3'd2, 3'd6, 1, 0, 2'b00, 1, 0}; // SUBI
    tbl[7]  = '{4'b1010, 3'd2, 3'd7, 3'd0, 1, 0, 2'b11, 0, 0}; // ORI
    tbl[8]  = '{4'b1011, 3'd1, 3'd4, 3'd2, 1, 0, 2'b10, 0, 0}; // ANDI
    tbl[9]  = '{4'b1100, 3'd0, 3'd5, 3'd7, 1, 0, 2'b01, 0, 0}; // XORI
    tbl[10] = '{4'b1111, 3'd2, 3'd3, 3'd4, 0, 1, 2'b00, 0, 0}; // illegal
    tbl[11] = '{4'b0010, 3'd1, 3'd1, 3'd1, 0, 1, 2'b00, 0, 0}; // illegal
    tbl[12] = '{4'b1101, 3'd6, 3'd6, 3'd6, 0, 1, 2'b00, 0, 0}; // illegal
    tbl[13] = '{4'b0000, 3'd2, 3'd5, 3'd3, 0, 0, 2'b00, 0, 1}; // ADD, start spam
    tbl[14] = '{4'b1001, 3'd3, 3'd0, 3'd1, 1, 0, 2'b00, 1, 1}; // SUBI, start spam
    v16     = '{4'b0110, 3'd1, 3'd2, 3'd6, 0, 0, 2'b01, 0, 0}; // XOR rd=6

    // Reset state
    #2;
    check("reset8", act8, '0);
    check("reset16", act16, '0);
    #5 rstn = 1;

    for (int i = 0; i < 15; i++) run_op(tbl[i], 8, 0, $sformatf("vec%0d", i));

    // Reset mid-EXEC (bit 4 is cycle 21), then a clean full sequence.
    run_op(tbl[0], 8, 21, "pre_rst");
    #1 rstn = 0;
    #1 check("rst_async", act8, '0);
    @(posedge clk);
    #1 check("rst_hold", act8, '0);
    #2 rstn = 1;
    run_op(tbl[0], 8, 0, "post_rst");

    // Wider instance
    run_op(v16, 16, 0, "w16_xor");
    run_op(tbl[6], 16, 0, "w16_subi");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errors);
    $finish;
  end

endmodule
